// File: rtl/unpack_message_1030.sv
// Receive-side unpacker for 1030 packed messages: input register, FIFO, validating output stage.
// Optional DEVICE_ID_FILTER_EN: drop drift reports whose device id differs from DEVICE_ID.
`timescale 1ns/1ps

// Generic synchronous FIFO, power-of-2 depth.
// Latency: a pushed entry is visible at head_dat one cycle after the push.
// Backpressure: none internally; the caller must not push when full unless it also pops.
module sync_fifo #(
  parameter int W     = 88,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head_dat = mem[rd_ptr];
  assign level    = cnt;
endmodule

// Decodes buffered 88-bit messages into Mode A/C or drift fields on a ready/valid port.
// Latency: valid_in sampled at edge N gives out_valid after edge N+2; 1 msg/cycle sustained.
// Backpressure: out_ready stalls the output stage; input is never stalled, FIFO overflow drops and counts.
module unpack_message_1030 #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DEVICE_ID  = 16'h0001,
  parameter int          CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [87:0]                   packed_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [1:0]                    out_type,
  output logic [5:0]                    ac_utc_ts,
  output logic [25:0]                   ac_clk_ts,
  output logic [12:0]                   ac_drift,
  output logic [23:0]                   ac_message,
  output logic [15:0]                   dr_device_id,
  output logic [31:0]                   dr_pps_count,
  output logic [15:0]                   dr_drift,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              err_count,
  output logic [CNT_W-1:0]              ovf_count
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef DEVICE_ID_FILTER_EN
  localparam bit ID_FILTER = 1'b1;
`else
  localparam bit ID_FILTER = 1'b0;
`endif

  typedef enum logic {ST_EMPTY, ST_FULL} stage_t;

  stage_t      state_q, state_d;
  logic        in_vld_q;
  logic [87:0] in_dat_q;
  logic [87:0] head_dat;
  logic        fifo_empty, fifo_full;
  logic        push, pop, load, drop, ovf;
  logic        head_ac, head_dr, head_ok, dr_id_ok;
  logic [71:0] stg_dat;
  logic [1:0]  stg_typ;

  // Input register keeps the packed bus timing-isolated from the FIFO write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      in_dat_q <= '0;
    end else begin
      in_vld_q <= valid_in;
      in_dat_q <= packed_in;
    end
  end

  sync_fifo #(.W(88), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_dat_q),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (fifo_level)
  );

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));

  assign dr_id_ok = !ID_FILTER || (head_dat[66:51] == DEVICE_ID);
  assign head_ac  = (head_dat[87:72] == 16'h0001) && (head_dat[26:24] == 3'b011);
  assign head_dr  = (head_dat[87:67] == 21'h1FABAD) && (head_dat[18:16] == 3'b100) && dr_id_ok;
  assign head_ok  = head_ac || head_dr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // The head is taken whenever the stage is free or is being emptied this cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ok) begin
            load    = 1'b1;
            state_d = ST_FULL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d = ST_EMPTY;
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_ok) begin
              load    = 1'b1;
              state_d = ST_FULL;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign push = in_vld_q && (!fifo_full || pop);
  assign ovf  = in_vld_q && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_dat <= '0;
      stg_typ <= 2'b00;
    end else if (load) begin
      stg_dat <= head_dat[71:0];
      stg_typ <= head_ac ? 2'b01 : 2'b10;
    end else if (state_d == ST_EMPTY) begin
      stg_dat <= '0;
      stg_typ <= 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      ovf_count <= '0;
    end else begin
      if (drop && (err_count != '1)) err_count <= err_count + 1'b1;
      if (ovf  && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
    end
  end

  assign out_valid    = (state_q == ST_FULL);
  assign out_type     = stg_typ;
  assign ac_utc_ts    = (stg_typ == 2'b01) ? stg_dat[71:66] : '0;
  assign ac_clk_ts    = (stg_typ == 2'b01) ? stg_dat[65:40] : '0;
  assign ac_drift     = (stg_typ == 2'b01) ? stg_dat[39:27] : '0;
  assign ac_message   = (stg_typ == 2'b01) ? stg_dat[23:0]  : '0;
  assign dr_device_id = (stg_typ == 2'b10) ? stg_dat[66:51] : '0;
  assign dr_pps_count = (stg_typ == 2'b10) ? stg_dat[50:19] : '0;
  assign dr_drift     = (stg_typ == 2'b10) ? stg_dat[15:0]  : '0;
endmodule

// File: tb/tb_unpack_message_1030.sv
// Randomized self-checking bench for unpack_message_1030 with a field-level scoreboard.
`timescale 1ns/1ps

module tb_unpack_message_1030;
  logic        clk = 1'b0;
  logic        rst, valid_in, out_ready;
  logic [87:0] packed_in;
  logic        out_valid;
  logic [1:0]  out_type;
  logic [5:0]  ac_utc_ts;
  logic [25:0] ac_clk_ts;
  logic [12:0] ac_drift;
  logic [23:0] ac_message;
  logic [15:0] dr_device_id;
  logic [31:0] dr_pps_count;
  logic [15:0] dr_drift;
  logic [2:0]  fifo_level;
  logic [15:0] err_count, ovf_count;

  typedef struct packed {
    logic [1:0]  typ;
    logic [5:0]  utc;
    logic [25:0] cts;
    logic [12:0] adr;
    logic [23:0] msg;
    logic [15:0] id;
    logic [31:0] pps;
    logic [15:0] ddr;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0, n_fail = 0, delivered = 0, exp_err = 0;

  unpack_message_1030 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .packed_in(packed_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_type(out_type),
    .ac_utc_ts(ac_utc_ts), .ac_clk_ts(ac_clk_ts), .ac_drift(ac_drift),
    .ac_message(ac_message), .dr_device_id(dr_device_id),
    .dr_pps_count(dr_pps_count), .dr_drift(dr_drift),
    .fifo_level(fifo_level), .err_count(err_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ac_exp(input logic [5:0] utc, input logic [25:0] cts,
                                  input logic [12:0] adr, input logic [23:0] msg);
    exp_t e = '0;
    e.typ = 2'b01; e.utc = utc; e.cts = cts; e.adr = adr; e.msg = msg;
    return e;
  endfunction

  function automatic exp_t dr_exp(input logic [15:0] id, input logic [31:0] pps,
                                  input logic [15:0] ddr);
    exp_t e = '0;
    e.typ = 2'b10; e.id = id; e.pps = pps; e.ddr = ddr;
    return e;
  endfunction

  function automatic logic [87:0] ac_pkt(input exp_t e, input logic [2:0] tag);
    return {16'h0001, e.utc, e.cts, e.adr, tag, e.msg};
  endfunction

  function automatic logic [87:0] dr_pkt(input exp_t e, input logic [2:0] tag);
    return {21'h1FABAD, e.id, e.pps, tag, e.ddr};
  endfunction

  task automatic compare_out(input exp_t e, input string p);
    chk({p, ".type"},  64'(out_type),     64'(e.typ));
    chk({p, ".utc"},   64'(ac_utc_ts),    64'(e.utc));
    chk({p, ".cts"},   64'(ac_clk_ts),    64'(e.cts));
    chk({p, ".adr"},   64'(ac_drift),     64'(e.adr));
    chk({p, ".msg"},   64'(ac_message),   64'(e.msg));
    chk({p, ".id"},    64'(dr_device_id), 64'(e.id));
    chk({p, ".pps"},   64'(dr_pps_count), 64'(e.pps));
    chk({p, ".ddr"},   64'(dr_drift),     64'(e.ddr));
  endtask

  // Scoreboard: every completed handshake must match the oldest expected message.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        compare_out(e, "deliv");
      end
      delivered++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [87:0] p);
    valid_in = 1'b1; packed_in = p;
    tick(1);
    valid_in = 1'b0; packed_in = '0;
  endtask

  task automatic lat_check(input string tag, input exp_t e);
    tick(1);
    chk({tag, ".lat_n1"}, 64'(out_valid), 64'd0);
    tick(1);
    chk({tag, ".lat_n2"}, 64'(out_valid), 64'd1);
    compare_out(e, tag);
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int k = 0;
    while (expq.size() != 0 && k < lim) begin tick(1); k++; end
    chk(tag, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   sent_v, outstanding, r;
    logic [2:0] tag;

    rst = 1'b1; valid_in = 1'b0; packed_in = '0; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst.valid", 64'(out_valid),    64'd0);
    chk("rst.type",  64'(out_type),     64'd0);
    chk("rst.level", 64'(fifo_level),   64'd0);
    chk("rst.err",   64'(err_count),    64'd0);
    chk("rst.ovf",   64'(ovf_count),    64'd0);
    chk("rst.msg",   64'(ac_message),   64'd0);
    chk("rst.pps",   64'(dr_pps_count), 64'd0);

    // Mode A/C reply
    e = ac_exp(6'd5, 26'h12345, 13'(-7), 24'hABCDEF);
    expq.push_back(e);
    send(ac_pkt(e, 3'b011));
    lat_check("t1", e);
    out_ready = 1'b1;
    wait_drain("t1.drain", 20);

    // Drift report
    out_ready = 1'b0;
    e = dr_exp(16'h0001, 32'hDEADBEEF, 16'(-300));
    expq.push_back(e);
    send(dr_pkt(e, 3'b100));
    lat_check("t2", e);
    chk("t2.ddr_const", 64'(dr_drift), 64'h0000_0000_0000_FED4);
    out_ready = 1'b1;
    wait_drain("t2.drain", 20);

    // Mode A/C header with bad tag
    e = ac_exp(6'd1, 26'd2, 13'd3, 24'd4);
    send(ac_pkt(e, 3'b111));
    exp_err++;
    for (int i = 0; i < 5; i++) begin
      chk("t3.no_valid", 64'(out_valid), 64'd0);
      tick(1);
    end
    chk("t3.err", 64'(err_count), 64'(exp_err));

    // Overflow with stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = ac_exp(6'(i), 26'(i * 3), 13'(i), 24'(24'h100 + i));
      if (i < 5) expq.push_back(e);
      valid_in = 1'b1; packed_in = ac_pkt(e, 3'b011);
      tick(1);
    end
    valid_in = 1'b0; packed_in = '0;
    tick(4);
    chk("t4.level", 64'(fifo_level), 64'd4);
    chk("t4.ovf",   64'(ovf_count),  64'd1);
    chk("t4.valid", 64'(out_valid),  64'd1);
    chk("t4.head",  64'(ac_message), 64'h100);
    tick(3);
    chk("t4.stable", 64'(ac_message), 64'h100);
    out_ready = 1'b1;
    wait_drain("t4.drain", 50);
    chk("t4.level_end", 64'(fifo_level), 64'd0);

    // Foreign device id
    e = dr_exp(16'h0002, 32'h0BAD_F00D, 16'h0123);
`ifdef DEVICE_ID_FILTER_EN
    exp_err++;
    send(dr_pkt(e, 3'b100));
    tick(6);
    chk("t5.filtered_valid", 64'(out_valid), 64'd0);
`else
    expq.push_back(e);
    send(dr_pkt(e, 3'b100));
    wait_drain("t5.drain", 20);
`endif
    chk("t5.err", 64'(err_count), 64'(exp_err));

    // Mid-operation reset with queued traffic
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ac_exp(6'd9, 26'd9, 13'd9, 24'(24'h200 + i));
      valid_in = 1'b1; packed_in = ac_pkt(e, 3'b011);
      tick(1);
    end
    valid_in = 1'b0; packed_in = '0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_err = 0;
    chk("t6.valid", 64'(out_valid),  64'd0);
    chk("t6.level", 64'(fifo_level), 64'd0);
    chk("t6.err",   64'(err_count),  64'd0);
    chk("t6.ovf",   64'(ovf_count),  64'd0);
    chk("t6.type",  64'(out_type),   64'd0);
    e = ac_exp(6'd33, 26'h3FFFFFF, 13'h1000, 24'h5A5A5A);
    expq.push_back(e);
    send(ac_pkt(e, 3'b011));
    lat_check("t6", e);
    out_ready = 1'b1;
    wait_drain("t6.drain", 20);

    // Random traffic kept below overflow; malformed only sent when nothing is outstanding
    sent_v = delivered;
    for (int it = 0; it < 400; it++) begin
      out_ready   = ($urandom_range(3) != 0);
      outstanding = sent_v - delivered;
      r           = $urandom_range(9);
      if (outstanding < 2 && r < 6) begin
        if ($urandom_range(1) == 0) begin
          e = ac_exp(6'($urandom), 26'($urandom), 13'($urandom), 24'($urandom));
          packed_in = ac_pkt(e, 3'b011);
        end else begin
          e = dr_exp(16'h0001, $urandom, 16'($urandom));
          packed_in = dr_pkt(e, 3'b100);
        end
        expq.push_back(e);
        valid_in = 1'b1;
        sent_v++;
      end else if (outstanding == 0 && r >= 8) begin
        e = ac_exp(6'($urandom), 26'($urandom), 13'($urandom), 24'($urandom));
        tag = 3'($urandom_range(7));
        if (tag == 3'b011) tag = 3'b111;
        packed_in = ($urandom_range(1) == 0) ? ac_pkt(e, tag)
                                             : {16'h0002, ac_pkt(e, 3'b011)[71:0]};
        valid_in = 1'b1;
        exp_err++;
      end else begin
        valid_in = 1'b0;
        packed_in = '0;
      end
      tick(1);
    end
    valid_in = 1'b0; packed_in = '0;
    out_ready = 1'b1;
    wait_drain("rnd.drain", 200);
    tick(4);
    chk("rnd.err",   64'(err_count),  64'(exp_err));
    chk("rnd.ovf",   64'(ovf_count),  64'd0);
    chk("rnd.level", 64'(fifo_level), 64'd0);
    chk("rnd.valid", 64'(out_valid),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
